// File: rtl/dtc_pkg.sv
// Shared codes, FSM state types and fast-code lookup for the DTC link endpoint.
// Optional build macro used by the endpoint: DTC_PARITY_EN.
package dtc_pkg;

   localparam logic [7:0] RDOCMD   = 8'hE2;
   localparam logic [7:0] SCLKSYNC = 8'hE4;
   localparam logic [7:0] RSTCMD   = 8'hE8;
   localparam logic [7:0] STREQ    = 8'hE9;
   localparam logic [7:0] RJECTCMD = 8'hEA;
   localparam logic [7:0] ARDOEND  = 8'hEF;
   localparam logic [7:0] SLOWCMD  = 8'hE1;

   typedef enum logic [2:0] {IDLE, HDR, CODE, ADDR, DATA, PAR} dec_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_SEND} rsp_state_t;

   function automatic logic is_fast_code(input logic [7:0] c);
      return (c == RDOCMD) || (c == SCLKSYNC) || (c == RSTCMD) ||
             (c == STREQ)  || (c == RJECTCMD) || (c == ARDOEND);
   endfunction

endpackage

// File: rtl/dtc_return_ser.sv
// Slow-read response engine: waits for register data (or times out), then
// serialises a start bit plus DATA_W bits MSB-first onto dtc_return.
module dtc_return_ser
   import dtc_pkg::*;
#(
   parameter int          DATA_W       = 32,
   parameter int          RD_TIMEOUT   = 256,
   parameter logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] read_data,
   input  logic              data_vld,
   output logic              busy,
   output logic              rd_timeout,
   output logic              dtc_return
);

   localparam int TW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [DATA_W-1:0] TO_WORD = DATA_W'(TIMEOUT_WORD);

   rsp_state_t        state, state_nx;
   logic [TW-1:0]     tcnt;
   logic [BW-1:0]     bcnt;
   logic [DATA_W-1:0] sr;
   logic              cap_data, cap_to;

   assign busy = (state != R_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= R_IDLE;
      else     state <= state_nx;
   end

   // data_vld takes priority over an expiring timer on the same edge
   always_comb begin
      state_nx = state;
      cap_data = 1'b0;
      cap_to   = 1'b0;
      case (state)
         R_IDLE: if (start) state_nx = R_WAIT;
         R_WAIT: begin
            if (data_vld) begin
               cap_data = 1'b1;
               state_nx = R_SEND;
            end else if (tcnt == TW'(RD_TIMEOUT - 1)) begin
               cap_to   = 1'b1;
               state_nx = R_SEND;
            end
         end
         R_SEND: if (bcnt == BW'(DATA_W)) state_nx = R_IDLE;
         default: state_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt       <= '0;
         bcnt       <= '0;
         sr         <= '0;
         dtc_return <= 1'b0;
         rd_timeout <= 1'b0;
      end else begin
         rd_timeout <= cap_to;
         case (state)
            R_IDLE: begin
               tcnt       <= '0;
               bcnt       <= '0;
               dtc_return <= 1'b0;
            end
            R_WAIT: begin
               tcnt <= tcnt + 1'b1;
               if (cap_data || cap_to) begin
                  sr         <= cap_data ? read_data : TO_WORD;
                  dtc_return <= 1'b1;
                  bcnt       <= '0;
               end
            end
            R_SEND: begin
               if (bcnt == BW'(DATA_W)) begin
                  dtc_return <= 1'b0;
               end else begin
                  dtc_return <= sr[DATA_W-1];
                  sr         <= {sr[DATA_W-2:0], 1'b0};
                  bcnt       <= bcnt + 1'b1;
               end
            end
            default: dtc_return <= 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/dtc_link_v2.sv
// DTC link endpoint: serial frame decoder for triggers, fast and slow commands.
// Build macro DTC_PARITY_EN appends an even-parity bit to slow frames.
module dtc_link_v2
   import dtc_pkg::*;
#(
   parameter int          ADDR_W       = 32,
   parameter int          DATA_W       = 32,
   parameter logic [7:0]  SLOW_CODE    = 8'hE1,
   parameter logic [7:0]  RST_CODE     = 8'hE8,
   parameter int          RD_TIMEOUT   = 256,
   parameter logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF
) (
   input  logic              dtc_clk,
   input  logic              rst,
   input  logic              dtc_trig,
   output logic              dtc_return,
   output logic              trig_l0,
   output logic              trig_l1,
   output logic              fast_vld,
   output logic [7:0]        fast_code,
   output logic              rstcmd,
   output logic              write,
   output logic              rd_req,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data,
   input  logic              data_vld,
   output logic              rd_timeout,
   output logic              rd_overrun,
   output logic              frame_err
);

   localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CW   = ($clog2(MAXW) > 3) ? $clog2(MAXW) : 3;
`ifdef DTC_PARITY_EN
   localparam int DSR_W = DATA_W;
`else
   localparam int DSR_W = DATA_W - 1;
`endif

   dec_state_t        state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [3:0]        code_sr;
   logic [7:0]        code;
   logic [ADDR_W-1:0] addr_sr;
   logic [DSR_W-1:0]  data_sr;
   logic [DATA_W-1:0] data_full;
   logic              ev_l0, ev_l1, ev_fast, ev_slow, ev_err;
   logic              rd_flag, rd_issue, rsp_busy;

   // The three leading ones of a command byte are implied by reaching CODE
   assign code = {3'b111, code_sr, dtc_trig};
`ifdef DTC_PARITY_EN
   logic par;
   assign data_full = data_sr;
`else
   assign data_full = {data_sr, dtc_trig};
`endif
   assign rd_flag  = addr_sr[ADDR_W-1];
   assign rd_issue = ev_slow && rd_flag && !rsp_busy;

   always_ff @(posedge dtc_clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      ev_l0    = 1'b0;
      ev_l1    = 1'b0;
      ev_fast  = 1'b0;
      ev_slow  = 1'b0;
      ev_err   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (dtc_trig) state_nx = HDR;
         end
         HDR: begin
            if (!dtc_trig) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               if (cnt == '0) ev_l0 = 1'b1;
               else           ev_l1 = 1'b1;
            end else if (cnt != '0) begin
               state_nx = CODE;
               cnt_nx   = '0;
            end
         end
         CODE: begin
            if (cnt == CW'(4)) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               if (code == SLOW_CODE)      state_nx = ADDR;
               else if (is_fast_code(code)) ev_fast = 1'b1;
               else                         ev_err  = 1'b1;
            end
         end
         ADDR: begin
            if (cnt == CW'(ADDR_W - 1)) begin
               state_nx = DATA;
               cnt_nx   = '0;
            end
         end
         DATA: begin
            if (cnt == CW'(DATA_W - 1)) begin
               cnt_nx = '0;
`ifdef DTC_PARITY_EN
               state_nx = PAR;
`else
               state_nx = IDLE;
               ev_slow  = 1'b1;
`endif
            end
         end
         PAR: begin
            state_nx = IDLE;
            cnt_nx   = '0;
`ifdef DTC_PARITY_EN
            if (par ^ dtc_trig) ev_err  = 1'b1;
            else                ev_slow = 1'b1;
`endif
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge dtc_clk or posedge rst) begin
      if (rst) begin
         code_sr <= '0;
         addr_sr <= '0;
         data_sr <= '0;
      end else begin
         case (state)
            CODE:    code_sr <= {code_sr[2:0], dtc_trig};
            ADDR:    addr_sr <= {addr_sr[ADDR_W-2:0], dtc_trig};
            DATA:    data_sr <= {data_sr[DSR_W-2:0], dtc_trig};
            default: ;
         endcase
      end
   end

`ifdef DTC_PARITY_EN
   always_ff @(posedge dtc_clk or posedge rst) begin
      if (rst)                                  par <= 1'b0;
      else if (state == CODE)                   par <= 1'b0;
      else if (state == ADDR || state == DATA)  par <= par ^ dtc_trig;
   end
`endif

   always_ff @(posedge dtc_clk or posedge rst) begin
      if (rst) begin
         trig_l0    <= 1'b0;
         trig_l1    <= 1'b0;
         fast_vld   <= 1'b0;
         fast_code  <= '0;
         rstcmd     <= 1'b0;
         write      <= 1'b0;
         rd_req     <= 1'b0;
         address    <= '0;
         write_data <= '0;
         rd_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         trig_l0   <= ev_l0;
         trig_l1   <= ev_l1;
         fast_vld  <= ev_fast;
         rstcmd    <= ev_fast && (code == RST_CODE);
         frame_err <= ev_err;
         write     <= ev_slow && !rd_flag;
         rd_req    <= rd_issue;
         if (ev_fast) fast_code <= code;
         if (ev_slow) address   <= addr_sr;
         if (ev_slow && !rd_flag) write_data <= data_full;
         // a read that arrives while a response is still pending is dropped
         if (ev_slow && rd_flag && rsp_busy) rd_overrun <= 1'b1;
      end
   end

   dtc_return_ser #(
      .DATA_W      (DATA_W),
      .RD_TIMEOUT  (RD_TIMEOUT),
      .TIMEOUT_WORD(TIMEOUT_WORD)
   ) u_ret (
      .clk       (dtc_clk),
      .rst       (rst),
      .start     (rd_issue),
      .read_data (read_data),
      .data_vld  (data_vld),
      .busy      (rsp_busy),
      .rd_timeout(rd_timeout),
      .dtc_return(dtc_return)
   );

endmodule
